// File: rtl/mcpu_exec_ctrl.sv
// mcpu_exec_ctrl: serial execute controller and register file feeding mcpu_alu.
// One instruction is accepted at a time and runs through a fixed four-state
// sequence, so throughput is one instruction every four cycles.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   instr, instr_valid      instruction {op[2:0], rd, rs1, rs2} and its valid
//   instr_ready             high while idle and able to accept an instruction
//   alu_opcode/r1/r2        registered opcode and operands driven to the ALU
//   alu_out, alu_overflow   combinational ALU result and carry out of ADD
//   done                    one-cycle pulse during write-back
//   ovf_flag                overflow of the most recent ALU operation
//   dbg_addr, dbg_data      combinational register readout
//
// state   | meaning
// S_IDLE  | ready for an instruction; latch it on valid
// S_READ  | read sources into ALU operands, or form LOADI/MOV result
// S_EXEC  | ALU ops capture result and overflow from the ALU
// S_WRITE | write result to rd, update ovf_flag for ALU ops, pulse done

module mcpu_exec_ctrl #(
   parameter int CMD_SIZE  = 2,
   parameter int WORD_SIZE = 2,
   parameter int REG_ADDR  = 2,
   localparam int INSTR_W  = 3 + 3*REG_ADDR
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [INSTR_W-1:0]   instr,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   output logic [CMD_SIZE-1:0]  alu_opcode,
   output logic [WORD_SIZE-1:0] alu_r1,
   output logic [WORD_SIZE-1:0] alu_r2,
   input  logic [WORD_SIZE-1:0] alu_out,
   input  logic                 alu_overflow,
   output logic                 done,
   output logic                 ovf_flag,
   input  logic [REG_ADDR-1:0]  dbg_addr,
   output logic [WORD_SIZE-1:0] dbg_data
);

   localparam int NREGS = 1 << REG_ADDR;
   localparam int IMM_W = 2*REG_ADDR;

   localparam logic [2:0] OP_LOADI = 3'd4;
   localparam logic [2:0] OP_MOV   = 3'd5;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

   state_t                 state_q, state_d;
   logic [INSTR_W-1:0]     instr_q, instr_d;
   logic [WORD_SIZE-1:0]   result_q, result_d;
   logic                   pend_ovf_q, pend_ovf_d;
   logic [CMD_SIZE-1:0]    alu_opcode_q, alu_opcode_d;
   logic [WORD_SIZE-1:0]   alu_r1_q, alu_r1_d;
   logic [WORD_SIZE-1:0]   alu_r2_q, alu_r2_d;
   logic                   ovf_flag_q, ovf_flag_d;
   logic [WORD_SIZE-1:0]   regs_q [NREGS];
   logic [WORD_SIZE-1:0]   regs_d [NREGS];

   logic [2:0]             op;
   logic [REG_ADDR-1:0]    rd, rs1, rs2;
   logic                   is_alu, is_write;
   logic [IMM_W+WORD_SIZE-1:0] imm_ext;

   always_comb begin
      op       = instr_q[INSTR_W-1 -: 3];
      rd       = instr_q[3*REG_ADDR-1 -: REG_ADDR];
      rs1      = instr_q[2*REG_ADDR-1 -: REG_ADDR];
      rs2      = instr_q[REG_ADDR-1:0];
      is_alu   = ~op[2];
      is_write = is_alu | (op == OP_LOADI) | (op == OP_MOV);
      // Zero-extend first so the low slice serves both truncation and extension.
      imm_ext  = {{WORD_SIZE{1'b0}}, rs1, rs2};
   end

   always_comb begin
      state_d      = state_q;
      instr_d      = instr_q;
      result_d     = result_q;
      pend_ovf_d   = pend_ovf_q;
      alu_opcode_d = alu_opcode_q;
      alu_r1_d     = alu_r1_q;
      alu_r2_d     = alu_r2_q;
      ovf_flag_d   = ovf_flag_q;
      regs_d       = regs_q;
      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               instr_d = instr;
               state_d = S_READ;
            end
         end
         S_READ: begin
            if (is_alu) begin
               alu_r1_d     = regs_q[rs1];
               alu_r2_d     = regs_q[rs2];
               alu_opcode_d = CMD_SIZE'(op[1:0]);
            end else if (op == OP_LOADI) begin
               result_d = imm_ext[WORD_SIZE-1:0];
            end else if (op == OP_MOV) begin
               result_d = regs_q[rs1];
            end
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (is_alu) begin
               result_d   = alu_out;
               pend_ovf_d = alu_overflow;
            end
            state_d = S_WRITE;
         end
         S_WRITE: begin
            if (is_write) regs_d[rd] = result_q;
            if (is_alu)   ovf_flag_d = pend_ovf_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         instr_q      <= '0;
         result_q     <= '0;
         pend_ovf_q   <= 1'b0;
         alu_opcode_q <= '0;
         alu_r1_q     <= '0;
         alu_r2_q     <= '0;
         ovf_flag_q   <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         instr_q      <= instr_d;
         result_q     <= result_d;
         pend_ovf_q   <= pend_ovf_d;
         alu_opcode_q <= alu_opcode_d;
         alu_r1_q     <= alu_r1_d;
         alu_r2_q     <= alu_r2_d;
         ovf_flag_q   <= ovf_flag_d;
         regs_q       <= regs_d;
      end
   end

   assign instr_ready = (state_q == S_IDLE);
   assign done        = (state_q == S_WRITE);
   assign alu_opcode  = alu_opcode_q;
   assign alu_r1      = alu_r1_q;
   assign alu_r2      = alu_r2_q;
   assign ovf_flag    = ovf_flag_q;
   assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_mcpu_exec_ctrl.sv
// Bench for mcpu_exec_ctrl: a reference register model predicts each
// instruction's outcome when it is driven; the prediction is popped and
// compared when the controller pulses done.

module tb_mcpu_exec_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [8:0] instr = '0;
   logic       instr_valid = 1'b0;
   logic       instr_ready;
   logic [1:0] alu_opcode, alu_r1, alu_r2, alu_out;
   logic       alu_overflow;
   logic       done, ovf_flag;
   logic [1:0] dbg_addr = '0;
   logic [1:0] dbg_data;

   mcpu_exec_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr        (instr),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .alu_opcode   (alu_opcode),
      .alu_r1       (alu_r1),
      .alu_r2       (alu_r2),
      .alu_out      (alu_out),
      .alu_overflow (alu_overflow),
      .done         (done),
      .ovf_flag     (ovf_flag),
      .dbg_addr     (dbg_addr),
      .dbg_data     (dbg_data)
   );

   always #5 clk = ~clk;

   // Behavioural stand-in for mcpu_alu.
   always_comb begin
      alu_overflow = 1'b0;
      case (alu_opcode)
         2'd0:    alu_out = alu_r1 & alu_r2;
         2'd1:    alu_out = alu_r1 | alu_r2;
         2'd2:    alu_out = alu_r1 ^ alu_r2;
         default: {alu_overflow, alu_out} = {1'b0, alu_r1} + {1'b0, alu_r2};
      endcase
   end

   int total = 0;
   int bad   = 0;

   task automatic tb_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [1:0]      rd;
      logic [1:0]      val;
      logic            alu;
      logic [1:0]      r1;
      logic [1:0]      r2;
      logic [1:0]      opc;
      logic            ovf;
      logic [3:0][1:0] regs;
   } exp_t;

   exp_t       exp_q[$];
   logic [1:0] ref_regs [4];
   logic       ref_ovf;

   task automatic ref_reset();
      for (int i = 0; i < 4; i++) ref_regs[i] = '0;
      ref_ovf = 1'b0;
      exp_q.delete();
   endtask

   task automatic predict(input logic [8:0] ins);
      exp_t       e;
      logic [2:0] op;
      logic [1:0] rd, rs1, rs2, a, b, v;
      logic [3:0] imm;
      logic [2:0] sum;
      logic       c, wr;
      op = ins[8:6]; rd = ins[5:4]; rs1 = ins[3:2]; rs2 = ins[1:0];
      a = ref_regs[rs1]; b = ref_regs[rs2];
      imm = {rs1, rs2};
      c = 1'b0; wr = 1'b1; v = '0;
      case (op)
         3'd0: v = a & b;
         3'd1: v = a | b;
         3'd2: v = a ^ b;
         3'd3: begin sum = 3'(a) + 3'(b); v = sum[1:0]; c = sum[2]; end
         3'd4: v = imm[1:0];
         3'd5: v = a;
         default: wr = 1'b0;
      endcase
      if (wr) ref_regs[rd] = v;
      if (!op[2]) ref_ovf = c;
      e.rd = rd; e.val = v; e.alu = !op[2];
      e.r1 = a; e.r2 = b; e.opc = op[1:0]; e.ovf = ref_ovf;
      for (int i = 0; i < 4; i++) e.regs[i] = ref_regs[i];
      exp_q.push_back(e);
   endtask

   task automatic check_state(input exp_t e);
      for (int i = 0; i < 4; i++) begin
         dbg_addr = 2'(i);
         #1;
         tb_check($sformatf("reg%0d", i), 32'(dbg_data), 32'(e.regs[i]));
      end
      tb_check("ovf_flag", 32'(ovf_flag), 32'(e.ovf));
   endtask

   // Entered just after accepting edge T; done is expected in cycle T+3.
   task automatic wait_done_check();
      int   seen = 0;
      exp_t e;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (n == 2 && exp_q.size() > 0 && exp_q[0].alu) begin
            tb_check("exec_alu_r1", 32'(alu_r1), 32'(exp_q[0].r1));
            tb_check("exec_alu_r2", 32'(alu_r2), 32'(exp_q[0].r2));
            tb_check("exec_alu_opc", 32'(alu_opcode), 32'(exp_q[0].opc));
         end
         if (done) begin seen = n; break; end
      end
      tb_check("done_latency", 32'(seen), 32'd3);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) tb_check("queue_nonempty", 32'd0, 32'd1);
      else begin
         e = exp_q.pop_front();
         check_state(e);
      end
      @(negedge clk);
      tb_check("done_one_cycle", 32'(done), 32'd0);
      tb_check("ready_after", 32'(instr_ready), 32'd1);
   endtask

   task automatic run(input logic [8:0] ins);
      predict(ins);
      instr = ins;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      instr = 9'($urandom);
      wait_done_check();
   endtask

   function automatic logic [8:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs1, input logic [1:0] rs2);
      return {op, rd, rs1, rs2};
   endfunction

   initial begin
      exp_t e;
      int   pulses;
      ref_reset();

      // Reset state
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tb_check("rst_ready", 32'(instr_ready), 32'd1);
      tb_check("rst_done", 32'(done), 32'd0);
      tb_check("rst_ovf", 32'(ovf_flag), 32'd0);
      tb_check("rst_r1", 32'(alu_r1), 32'd0);
      tb_check("rst_r2", 32'(alu_r2), 32'd0);
      tb_check("rst_opc", 32'(alu_opcode), 32'd0);
      for (int i = 0; i < 4; i++) begin
         dbg_addr = 2'(i);
         #1;
         tb_check($sformatf("rst_reg%0d", i), 32'(dbg_data), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Load and ADD with carry, then XOR clears the flag, LOADI keeps it
      run(mk(3'd4, 2'd1, 2'd0, 2'd3));
      run(mk(3'd4, 2'd2, 2'd0, 2'd2));
      run(mk(3'd3, 2'd3, 2'd1, 2'd2));
      run(mk(3'd2, 2'd0, 2'd1, 2'd1));
      run(mk(3'd4, 2'd0, 2'd0, 2'd2));
      run(mk(3'd4, 2'd3, 2'd0, 2'd0));

      // Busy handshake: A accepted at T, B held and accepted at T+4
      predict(mk(3'd4, 2'd1, 2'd0, 2'd1));
      predict(mk(3'd4, 2'd2, 2'd0, 2'd1));
      instr = mk(3'd4, 2'd1, 2'd0, 2'd1);
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr = mk(3'd4, 2'd2, 2'd0, 2'd1);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         tb_check($sformatf("busy_ready_k%0d", k), 32'(instr_ready), 32'(k == 4 || k == 8));
         tb_check($sformatf("busy_done_k%0d", k), 32'(done), 32'(k == 3 || k == 7));
         if (k == 4) begin
            e = exp_q.pop_front();
            dbg_addr = e.rd;
            #1;
            tb_check("busy_first_wr", 32'(dbg_data), 32'(e.val));
         end
         if (k == 5) instr_valid = 1'b0;
      end
      e = exp_q.pop_front();
      check_state(e);

      // Async reset during EXEC of ADD r3,r1,r2
      instr = mk(3'd3, 2'd3, 2'd1, 2'd2);
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      ref_reset();
      dbg_addr = 2'd3;
      #1;
      tb_check("midrst_r3", 32'(dbg_data), 32'd0);
      tb_check("midrst_ready", 32'(instr_ready), 32'd1);
      pulses = 0;
      repeat (2) begin @(negedge clk); if (done) pulses++; end
      rst_n = 1'b1;
      #1;
      tb_check("midrst_ready_rel", 32'(instr_ready), 32'd1);
      repeat (5) begin @(negedge clk); if (done) pulses++; end
      tb_check("midrst_no_done", 32'(pulses), 32'd0);
      tb_check("midrst_r3_after", 32'(dbg_data), 32'd0);

      // Aliasing, NOP, MOV
      run(mk(3'd4, 2'd1, 2'd0, 2'd1));
      run(mk(3'd4, 2'd2, 2'd0, 2'd1));
      run(mk(3'd3, 2'd1, 2'd1, 2'd2));
      run(mk(3'd6, 2'd3, 2'd1, 2'd2));
      run(mk(3'd5, 2'd0, 2'd1, 2'd0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1);
   end

endmodule

// File: doc/mcpu_exec_ctrl.md
Name: mcpu_exec_ctrl

Overview:
Execute controller and register file that sits directly upstream of the micro-CPU ALU (mcpu_alu). It accepts one instruction at a time over a valid/ready handshake and reads source registers into registered ALU operand and opcode outputs. It captures the ALU result and overflow, then writes the result back to the register file. The sequence is a fixed 4-state FSM, so throughput is one instruction per 4 cycles.

Parameters:
CMD_SIZE, 2, ALU opcode width; must match mcpu_alu.
WORD_SIZE, 2, data word width; must match mcpu_alu.
REG_ADDR, 2, register index width. The register count is 2**REG_ADDR.
(derived) INSTR_W = 3 + 3*REG_ADDR. This is not overridable.

Ports:
clk  in  1  single rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
instr  in  INSTR_W  instruction, encoded {op[2:0], rd, rs1, rs2}.
instr_valid  in  1  instruction present.
instr_ready  out  1  controller can accept an instruction.
alu_opcode  out  CMD_SIZE  registered opcode to ALU.
alu_r1  out  WORD_SIZE  registered operand A to ALU.
alu_r2  out  WORD_SIZE  registered operand B to ALU.
alu_out  in  WORD_SIZE  combinational ALU result.
alu_overflow  in  1  ALU OVERFLOW (carry out of ADD).
done  out  1  one-cycle pulse at write-back.
ovf_flag  out  1  sticky-until-next-ALU-op overflow flag.
dbg_addr  in  REG_ADDR  debug read index.
dbg_data  out  WORD_SIZE  combinational register readout.

Behaviour:
- Opcodes:
  - 0 AND, 1 OR, 2 XOR, 3 ADD: ALU ops; alu_opcode = op[1:0].
  - 4 LOADI: rd <= {rs1,rs2} truncated or zero-extended to WORD_SIZE.
  - 5 MOV: rd <= reg[rs1].
  - 6, 7 NOP: no write.
- Reset (async, rst_n=0):
  - All registers, alu_opcode, alu_r1, alu_r2, ovf_flag and done go to 0.
  - The FSM goes to IDLE and instr_ready goes to 1.
  - An in-flight instruction is discarded with no write-back.
- FSM states: IDLE -> READ -> EXEC -> WRITE -> IDLE.
  - IDLE: instr_ready=1. On instr_valid&instr_ready at edge T, latch instr and go to READ. Otherwise stay in IDLE.
  - READ (T+1): instr_ready=0.
    - ALU ops: alu_r1<=reg[rs1], alu_r2<=reg[rs2], alu_opcode<=op[1:0].
    - LOADI/MOV: the internal result register is loaded from the immediate or reg[rs1]; ALU outputs hold their previous value.
    - Go to EXEC.
  - EXEC (T+2): ALU ops capture alu_out into the result register and alu_overflow into the pending-overflow register. Go to WRITE.
  - WRITE (T+3):
    - done=1 for exactly this cycle.
    - ALU/LOADI/MOV: reg[rd] <= result.
    - ALU ops only: ovf_flag <= pending overflow. LOADI, MOV and NOP leave ovf_flag unchanged.
    - Go to IDLE; instr_ready=1 again from T+4.
- Handshake:
  - instr_valid while not in IDLE is ignored; no buffering.
  - The instruction is sampled only at the accepting edge, so later changes to instr are ignored.
- Hazards: rd equal to rs1 or rs2 reads the old value in READ, and the write takes effect at WRITE. No forwarding is needed because execution is strictly serial.
- Arithmetic: result width is WORD_SIZE and ADD wraps modulo 2**WORD_SIZE. The carry is taken from alu_overflow only; no local recomputation.
- dbg_data = reg[dbg_addr], combinational. It reflects a write from the clock edge that ends WRITE.
- All register indices are in range by construction; there is no error path.

Test Plan:
- Reset: assert rst_n=0 for 2 cycles -> all regs 0, dbg_data=0 for every index, instr_ready=1, done=0, ovf_flag=0, alu_r1=alu_r2=0.
- Load and ADD with carry (WORD_SIZE=2):
  - Stimulus: LOADI r1,3; LOADI r2,2; ADD r3,r1,r2.
  - Response: during EXEC of the ADD, alu_r1=3, alu_r2=2, alu_opcode=2'b11. At that instruction's WRITE, done pulses and r3=1, ovf_flag=1. The accepting edge is at T, so done is at T+3.
- XOR clears the flag: XOR r0,r1,r1 after the previous test -> r0=0, ovf_flag=0. Then LOADI r0,2 -> ovf_flag stays 0 and r0=2.
- Busy handshake: hold instr_valid=1 with two different instructions in consecutive cycles -> instr_ready is low at T+1..T+3. Only the first is executed. The held instruction is accepted at T+4, and done pulses at T+3 and T+7.
- Async reset mid-operation: deassert rst_n during EXEC of ADD r3,r1,r2 (r3 previously 0, r1=1, r2=1) -> done never pulses and r3 reads 0 immediately. After release, instr_ready=1 on the first cycle.
- Aliasing and NOP:
  - With r1=1, r2=1, ADD r1,r1,r2 -> r1=2, ovf_flag=0.
  - Then op=6 NOP -> done pulses once, all regs unchanged, ovf_flag unchanged.
  - Then MOV r0,r1 -> r0=2.
